pixel_tx_framer: RTL and testbench
==================================

Name: pixel_tx_framer

Overview:
- Downstream of the edge-detection stage; upstream of the UART transmitter.
- Accepts processed pixel bytes on a one-cycle strobe and buffers them in a small FIFO.
- Emits them as framed packets: one SYNC byte, then exactly FRAME_LEN pixel bytes.
- Paces bytes to the UART with a transmit-pulse / busy_tx handshake, so bursty pixel output never loses bytes while the FIFO has room.

Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 entries (16).
- FRAME_LEN, 64: pixel bytes per frame, legal range 1..255.
- SYNC_BYTE, 8'hA5: header byte sent at the start of every frame.

Ports:
- clk  in  1: system clock, 50 MHz.
- rst_n  in  1: asynchronous active-low reset.
- pix_valid  in  1: one-cycle strobe; pix_data is valid in this cycle.
- pix_data  in  8: processed pixel from the edge stage.
- busy_tx  in  1: UART transmitter busy.
- transmit  out  1: one-cycle pulse; UART latches data_tx.
- data_tx  out  8: byte to send; held stable from the pulse until the handshake completes.
- frame_done  out  1: one-cycle pulse after the final byte of a frame completes.
- overflow  out  1: sticky; set when a push is dropped.
- fifo_level  out  DEPTH_LOG2+1: current FIFO occupancy.

Behaviour:
- Reset (async, rst_n low), all outputs and state cleared:
  - transmit=0, data_tx=8'h00, frame_done=0, overflow=0, fifo_level=0.
  - FIFO pointers 0, FSM in IDLE, pixel counter 0.
  - Reset mid-frame abandons the frame; no partial-frame resume.
- FIFO:
  - Push when pix_valid=1 and FIFO not full.
  - Pix_valid while full: byte dropped, overflow set, level unchanged.
  - Push and pop in the same cycle when full: pop frees a slot, push accepted, level unchanged, overflow not set.
  - Pop never occurs when empty; no bypass path (minimum latency pix_valid -> transmit is 2 cycles).
  - Pointers wrap modulo depth; full/empty distinguished by the extra MSB.
- FSM:
  - IDLE: when FIFO non-empty -> load data_tx=SYNC_BYTE, go to SEND.
  - SEND: if busy_tx=0, pulse transmit for 1 cycle -> WAIT_HI.
  - WAIT_HI: wait for busy_tx=1 -> WAIT_LO. Tolerates a UART that raises busy one or more cycles late.
  - WAIT_LO: wait for busy_tx=0, then:
    - After SYNC -> DATA.
    - After a data byte with counter < FRAME_LEN -> DATA.
    - After the last byte -> DONE.
  - DATA: if FIFO non-empty, pop, load data_tx, increment counter -> SEND. Otherwise stall in DATA indefinitely; a frame is never truncated.
  - DONE: pulse frame_done 1 cycle, clear counter -> IDLE.
- Pixel counter: width 8, counts data bytes only (SYNC excluded).
- data_tx changes only on entry to SEND; stable at least from the transmit pulse until WAIT_LO exits.
- Transmit is never asserted while busy_tx=1.
- Pixels arriving during SYNC or handshake states are buffered normally.

Optional Feature:
- PIXEL_TX_FRAMER_CHECKSUM_EN defined:
  - After the final data byte, FSM passes through CSUM before DONE.
  - CSUM sends a checksum byte = two's complement of the 8-bit modulo-256 sum of the frame's data bytes; SYNC is excluded. The data bytes plus the checksum therefore sum to 8'h00.
  - Sent with the same SEND/WAIT_HI/WAIT_LO handshake.
  - The sum accumulator clears in IDLE.
- Not defined: no CSUM state, no accumulator logic; the frame ends after data byte FRAME_LEN.

Test Plan:
- Basic frame: FRAME_LEN=4, push 8'h01,02,03,04 on consecutive cycles; UART model raises busy 1 cycle after transmit and holds it 10 cycles -> transmit pulses carry A5,01,02,03,04; frame_done pulses once; fifo_level returns to 0; overflow=0.
- Stall mid-frame: FRAME_LEN=4, push 2 bytes, wait 200 cycles, push 2 more -> A5,b0,b1 sent; FSM idles in DATA with no transmit pulses; then b2,b3 sent; a single frame_done.
- Overflow: hold busy_tx=1 constantly, push 20 bytes with DEPTH_LOG2=4 -> fifo_level saturates at 16 (first byte may already be popped, then 16); overflow=1 and stays 1 after busy_tx is released.
- Full + simultaneous: FIFO full, release busy_tx so a pop happens in the same cycle as pix_valid -> pushed byte accepted, level stays 16, overflow stays 0.
- Checksum (macro on): FRAME_LEN=3, data 8'h10,20,30 -> bytes A5,10,20,30,A0.
- Reset mid-frame: assert rst_n=0 during WAIT_LO of the 2nd data byte -> all outputs 0 immediately; after release, the next pushed byte starts a fresh frame with A5.

Source files
------------

// File: rtl/pixel_tx_framer_if.sv
// Pixel-in / UART-out signal bundle for pixel_tx_framer.
// The slave modport is the framer itself; the master modport is its environment.
interface pixel_tx_framer_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  pix_valid;
  logic [7:0]            pix_data;
  logic                  busy_tx;
  logic                  transmit;
  logic [7:0]            data_tx;
  logic                  frame_done;
  logic                  overflow;
  logic [DEPTH_LOG2:0]   fifo_level;

  modport master (
    output pix_valid, pix_data, busy_tx,
    input  transmit, data_tx, frame_done, overflow, fifo_level
  );

  modport slave (
    input  pix_valid, pix_data, busy_tx,
    output transmit, data_tx, frame_done, overflow, fifo_level
  );
endinterface

// File: rtl/pixel_tx_framer.sv
// Buffers pixel bytes in a FIFO and sends SYNC + FRAME_LEN bytes per frame to a UART.
// Optional trailing checksum byte when PIXEL_TX_FRAMER_CHECKSUM_EN is defined.
module pixel_tx_framer #(
  parameter int         DEPTH_LOG2 = 4,
  parameter int         FRAME_LEN  = 64,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  pixel_tx_framer_if.slave  bus
);

  localparam int         DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [7:0] FRAME_LEN_B = 8'(FRAME_LEN);
  localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2+1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_HI,
    WAIT_LO,
    DATA,
    DONE
`ifdef PIXEL_TX_FRAMER_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          mem_q [DEPTH];
  logic [7:0]          mem_d [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          data_tx_q, data_tx_d;
  logic                overflow_q, overflow_d;
`ifdef PIXEL_TX_FRAMER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
  logic                csum_sent_q, csum_sent_d;
`endif

  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic                drop;
  logic [7:0]          head;
  logic                transmit;
  logic                frame_done;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign head  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  // The FSM is the only consumer; a pop in the same cycle frees room for a push when full.
  assign pop  = (state_q == DATA) && !empty;
  assign push = bus.pix_valid && (!full || pop);
  assign drop = bus.pix_valid && full && !pop;

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = bus.pix_data;
    end
    wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    overflow_d = overflow_q | drop;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_tx_d  = data_tx_q;
    transmit   = 1'b0;
    frame_done = 1'b0;
`ifdef PIXEL_TX_FRAMER_CHECKSUM_EN
    sum_d       = sum_q;
    csum_sent_d = csum_sent_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
`ifdef PIXEL_TX_FRAMER_CHECKSUM_EN
        sum_d       = 8'd0;
        csum_sent_d = 1'b0;
`endif
        if (!empty) begin
          data_tx_d = SYNC_BYTE;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (!bus.busy_tx) begin
          transmit = 1'b1;
          state_d  = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bus.busy_tx) begin
          state_d = WAIT_LO;
        end
      end
      // cnt_q is 0 right after SYNC, so the same compare covers SYNC and data bytes.
      WAIT_LO: begin
        if (!bus.busy_tx) begin
          if (cnt_q < FRAME_LEN_B) begin
            state_d = DATA;
          end else begin
`ifdef PIXEL_TX_FRAMER_CHECKSUM_EN
            state_d = csum_sent_q ? DONE : CSUM;
`else
            state_d = DONE;
`endif
          end
        end
      end
      DATA: begin
        if (!empty) begin
          data_tx_d = head;
          cnt_d     = cnt_q + 8'd1;
          state_d   = SEND;
`ifdef PIXEL_TX_FRAMER_CHECKSUM_EN
          sum_d     = sum_q + head;
`endif
        end
      end
`ifdef PIXEL_TX_FRAMER_CHECKSUM_EN
      CSUM: begin
        data_tx_d   = ~sum_q + 8'd1;
        csum_sent_d = 1'b1;
        state_d     = SEND;
      end
`endif
      DONE: begin
        frame_done = 1'b1;
        cnt_d      = 8'd0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= 8'd0;
      data_tx_q  <= 8'h00;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
`ifdef PIXEL_TX_FRAMER_CHECKSUM_EN
      sum_q       <= 8'd0;
      csum_sent_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      data_tx_q  <= data_tx_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
`ifdef PIXEL_TX_FRAMER_CHECKSUM_EN
      sum_q       <= sum_d;
      csum_sent_q <= csum_sent_d;
`endif
    end
  end

  assign bus.transmit   = transmit;
  assign bus.data_tx    = data_tx_q;
  assign bus.frame_done = frame_done;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_level = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_pixel_tx_framer.sv
// Directed self-checking bench for pixel_tx_framer with a small busy_tx UART model.
// Covers the checksum frame too when PIXEL_TX_FRAMER_CHECKSUM_EN is defined.
module tb_pixel_tx_framer;

  localparam int DEPTH_LOG2 = 4;
`ifdef PIXEL_TX_FRAMER_CHECKSUM_EN
  localparam int FRAME_LEN = 3;
`else
  localparam int FRAME_LEN = 4;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic manual_busy;
  logic auto_en;
  logic model_busy;
  int   model_cnt;
  int   checks = 0;
  int   errors = 0;
  int   fd_count = 0;
  int   busy_viol = 0;
  logic [7:0] tx_log [$];

  always #10 clk = ~clk;

  pixel_tx_framer_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  pixel_tx_framer #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .FRAME_LEN  (FRAME_LEN),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.busy_tx = manual_busy | model_busy;

  // UART model: busy rises the cycle after a transmit pulse and stays high 10 cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_busy <= 1'b0;
      model_cnt  <= 0;
    end else begin
      if (bus.transmit) begin
        tx_log.push_back(bus.data_tx);
        if (bus.busy_tx) busy_viol++;
        if (auto_en) begin
          model_busy <= 1'b1;
          model_cnt  <= 10;
        end
      end else if (model_cnt > 0) begin
        model_cnt <= model_cnt - 1;
        if (model_cnt == 1) model_busy <= 1'b0;
      end
      if (bus.frame_done) fd_count++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    bus.pix_valid = 1'b1;
    bus.pix_data  = b;
    @(negedge clk);
    bus.pix_valid = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    bus.pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitTx(input string tag, input int target, input int budget);
    int k = 0;
    while (tx_log.size() < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, tx_log.size(), target);
  endtask

  task automatic waitFrame(input string tag, input int target, input int budget);
    int k = 0;
    while (fd_count < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, fd_count, target);
  endtask

  task automatic checkBytes(input string tag, input int base, input logic [7:0] exp_b [$]);
    for (int i = 0; i < exp_b.size(); i++) begin
      if (base + i < tx_log.size())
        checkOutput($sformatf("%s[%0d]", tag, i), {24'd0, tx_log[base+i]}, {24'd0, exp_b[i]});
      else
        checkOutput($sformatf("%s[%0d]_missing", tag, i), tx_log.size(), base + i + 1);
    end
  endtask

  initial begin
    int base;
    int fd0;
    logic [7:0] exp_b [$];

    rst_n         = 1'b0;
    manual_busy   = 1'b0;
    auto_en       = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_data  = 8'h00;
    #1;
    checkOutput("rst_transmit", bus.transmit, 0);
    checkOutput("rst_data_tx", bus.data_tx, 0);
    checkOutput("rst_frame_done", bus.frame_done, 0);
    checkOutput("rst_overflow", bus.overflow, 0);
    checkOutput("rst_level", bus.fifo_level, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame
    base = tx_log.size();
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    applyStimulus(8'h04);
    waitTx("basic_tx_count", base + 5, 300);
    waitFrame("basic_frame_done", 1, 60);
    repeat (20) @(negedge clk);
    exp_b = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04};
    checkBytes("basic_byte", base, exp_b);
    checkOutput("basic_single_done", fd_count, 1);
    checkOutput("basic_level", bus.fifo_level, 0);
    checkOutput("basic_overflow", bus.overflow, 0);

    // Stall mid-frame
    base = tx_log.size();
    fd0  = fd_count;
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    waitTx("stall_tx_count", base + 3, 200);
    repeat (200) @(negedge clk);
    checkOutput("stall_no_tx", tx_log.size(), base + 3);
    checkOutput("stall_no_done", fd_count, fd0);
    checkOutput("stall_level", bus.fifo_level, 0);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    waitTx("stall_tx_resume", base + 5, 200);
    waitFrame("stall_frame_done", fd0 + 1, 60);
    repeat (20) @(negedge clk);
    exp_b = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44};
    checkBytes("stall_byte", base, exp_b);
    checkOutput("stall_single_done", fd_count, fd0 + 1);

    // Reset during WAIT_LO of the second data byte
    base = tx_log.size();
    applyStimulus(8'h55);
    applyStimulus(8'h66);
    applyStimulus(8'h77);
    applyStimulus(8'h88);
    waitTx("midrst_tx_count", base + 3, 200);
    repeat (3) @(negedge clk);
    checkOutput("midrst_level_before", bus.fifo_level, 2);
    checkOutput("midrst_data_before", bus.data_tx, 8'h66);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_transmit", bus.transmit, 0);
    checkOutput("midrst_data_tx", bus.data_tx, 0);
    checkOutput("midrst_frame_done", bus.frame_done, 0);
    checkOutput("midrst_level", bus.fifo_level, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    base = tx_log.size();
    fd0  = fd_count;
    applyStimulus(8'h99);
    applyStimulus(8'h9A);
    applyStimulus(8'h9B);
    applyStimulus(8'h9C);
    waitFrame("midrst_fresh_done", fd0 + 1, 300);
    exp_b = '{8'hA5, 8'h99, 8'h9A, 8'h9B, 8'h9C};
    checkBytes("midrst_fresh", base, exp_b);

    // Overflow with busy held high
    doReset();
    manual_busy = 1'b1;
    base = tx_log.size();
    fd0  = fd_count;
    for (int i = 0; i < 20; i++) applyStimulus(8'h20 + 8'(i));
    checkOutput("ovf_level_sat", bus.fifo_level, 16);
    checkOutput("ovf_set", bus.overflow, 1);
    checkOutput("ovf_no_tx_busy", tx_log.size(), base);
    manual_busy = 1'b0;
    waitFrame("ovf_frame_done", fd0 + 1, 300);
    exp_b = '{8'hA5, 8'h20, 8'h21, 8'h22, 8'h23};
    checkBytes("ovf_byte", base, exp_b);
    checkOutput("ovf_sticky", bus.overflow, 1);
    doReset();
    checkOutput("ovf_rst_clear", bus.overflow, 0);
    checkOutput("ovf_rst_level", bus.fifo_level, 0);

    // Full FIFO with push and pop in the same cycle, hand-driven handshake
    auto_en     = 1'b0;
    manual_busy = 1'b1;
    for (int i = 0; i < 16; i++) applyStimulus(8'h30 + 8'(i));
    checkOutput("full_level", bus.fifo_level, 16);
    manual_busy = 1'b0;
    #1;
    checkOutput("full_sync_pulse", bus.transmit, 1);
    checkOutput("full_sync_byte", bus.data_tx, 8'hA5);
    @(negedge clk);
    manual_busy = 1'b1;
    repeat (2) @(negedge clk);
    manual_busy = 1'b0;
    @(negedge clk);
    applyStimulus(8'h40);
    checkOutput("full_simul_level", bus.fifo_level, 16);
    checkOutput("full_simul_overflow", bus.overflow, 0);
    checkOutput("full_first_data", bus.data_tx, 8'h30);
    checkOutput("full_data_pulse", bus.transmit, 1);
    auto_en = 1'b1;

`ifdef PIXEL_TX_FRAMER_CHECKSUM_EN
    // Checksum frame
    doReset();
    base = tx_log.size();
    fd0  = fd_count;
    applyStimulus(8'h10);
    applyStimulus(8'h20);
    applyStimulus(8'h30);
    waitFrame("csum_frame_done", fd0 + 1, 300);
    exp_b = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'hA0};
    checkBytes("csum_byte", base, exp_b);
`endif

    checkOutput("tx_while_busy", busy_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
